// File: rtl/crc_frame_ctrl_if.sv
// Stream and result handshake bundle for the CRC frame controller.
// slave = controller side, master = datapath/consumer side.
interface crc_frame_ctrl_if #(
  parameter int DATA_WIDTH = 48,
  parameter int CRC_WIDTH  = 32,
  parameter int LEN_W      = 9
);
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_valid_i;
  logic                  s_last_i;
  logic                  s_ready_o;
  logic [CRC_WIDTH-1:0]  crc_o;
  logic [LEN_W-1:0]      len_o;
  logic                  err_o;
  logic                  crc_valid_o;
  logic                  crc_ready_i;

  modport slave (
    input  s_data_i, s_valid_i, s_last_i, crc_ready_i,
    output s_ready_o, crc_o, len_o, err_o, crc_valid_o
  );

  modport master (
    output s_data_i, s_valid_i, s_last_i, crc_ready_i,
    input  s_ready_o, crc_o, len_o, err_o, crc_valid_o
  );
endinterface

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for a parallel CRC engine: clears, feeds, waits out
// engine latency and returns CRC/length/overflow on a handshake port.
module crc_frame_ctrl #(
  parameter  int DATA_WIDTH = 48,
  parameter  int CRC_WIDTH  = 32,
  parameter  int ENG_LAT    = 1,
  parameter  int MAX_WORDS  = 256,
  localparam int LEN_W      = $clog2(MAX_WORDS + 1),
  localparam int LAT_W      = $clog2(ENG_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  crc_frame_ctrl_if.slave       bus,
  output logic                  eng_clr_o,
  output logic [DATA_WIDTH-1:0] eng_data_o,
  output logic                  eng_valid_o,
  input  logic [CRC_WIDTH-1:0]  eng_crc_i,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, FEED, WAIT, DONE, DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  drain_q, drain_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  evld_q, evld_d;
  logic [CRC_WIDTH-1:0]  crc_q, crc_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  eo_q, eo_d;
  logic                  s_ready;
  logic                  hs;

  assign s_ready = (state_q == FEED) || (state_q == DRAIN);
  assign hs      = bus.s_valid_i && s_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    drain_d = drain_q;
    err_d   = err_q;
    data_d  = data_q;
    evld_d  = 1'b0;
    crc_d   = crc_q;
    len_d   = len_q;
    eo_d    = eo_q;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        drain_d = 1'b0;
        err_d   = 1'b0;
        if (bus.s_valid_i) state_d = CLEAR;
      end
      CLEAR: state_d = FEED;
      FEED: begin
        if (hs) begin
          data_d = bus.s_data_i;
          evld_d = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (bus.s_last_i) begin
            state_d = WAIT;
            lat_d   = LAT_W'(ENG_LAT);
          end else if (cnt_q == LEN_W'(MAX_WORDS - 1)) begin
            // overflow: rest of the frame is discarded in DRAIN
            state_d = WAIT;
            lat_d   = LAT_W'(ENG_LAT);
            drain_d = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          crc_d   = eng_crc_i;
          len_d   = cnt_q;
          eo_d    = err_q;
          state_d = DONE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.crc_ready_i) state_d = drain_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (hs && bus.s_last_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      drain_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      evld_q  <= 1'b0;
      crc_q   <= '0;
      len_q   <= '0;
      eo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      data_q  <= data_d;
      evld_q  <= evld_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      eo_q    <= eo_d;
    end
  end

  assign bus.s_ready_o   = s_ready;
  assign bus.crc_o       = crc_q;
  assign bus.len_o       = len_q;
  assign bus.err_o       = eo_q;
  assign bus.crc_valid_o = (state_q == DONE);
  assign eng_clr_o       = (state_q == CLEAR);
  assign eng_data_o      = data_q;
  assign eng_valid_o     = evld_q;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Directed bench for crc_frame_ctrl: DUT A (ENG_LAT=1, MAX_WORDS=4)
// and DUT B (ENG_LAT=3, MAX_WORDS=256) with a cycle-stamped engine.
module tb_crc_frame_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crc_frame_ctrl_if #(.DATA_WIDTH(48), .CRC_WIDTH(32), .LEN_W(3)) bus_a ();
  crc_frame_ctrl_if #(.DATA_WIDTH(48), .CRC_WIDTH(32), .LEN_W(9)) bus_b ();

  logic        clr_a, evld_a, busy_a;
  logic [47:0] edata_a;
  logic [31:0] ecrc_a;
  logic        clr_b, evld_b, busy_b;
  logic [47:0] edata_b;
  logic [31:0] ecrc_b;
  logic [15:0] cyc = '0;

  always @(posedge clk) cyc <= cyc + 16'd1;
  assign ecrc_b = {16'hC0DE, cyc};

  crc_frame_ctrl #(
    .DATA_WIDTH(48), .CRC_WIDTH(32), .ENG_LAT(1), .MAX_WORDS(4)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .eng_clr_o(clr_a), .eng_data_o(edata_a), .eng_valid_o(evld_a),
    .eng_crc_i(ecrc_a), .busy_o(busy_a)
  );

  crc_frame_ctrl #(
    .DATA_WIDTH(48), .CRC_WIDTH(32), .ENG_LAT(3), .MAX_WORDS(256)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .eng_clr_o(clr_b), .eng_data_o(edata_b), .eng_valid_o(evld_b),
    .eng_crc_i(ecrc_b), .busy_o(busy_b)
  );

  int n_asrt = 0;
  int n_fail = 0;
  logic [47:0] w [0:6];
  logic [15:0] c_last;
  logic [31:0] exp_b;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    w[0] = 48'h111111111111; w[1] = 48'h222222222222;
    w[2] = 48'h333333333333; w[3] = 48'h444444444444;
    w[4] = 48'h555555555555; w[5] = 48'h666666666666;
    w[6] = 48'h777777777777;
    rst = 1'b1;
    bus_a.s_data_i = '0; bus_a.s_valid_i = 1'b0;
    bus_a.s_last_i = 1'b0; bus_a.crc_ready_i = 1'b1;
    bus_b.s_data_i = '0; bus_b.s_valid_i = 1'b0;
    bus_b.s_last_i = 1'b0; bus_b.crc_ready_i = 1'b1;
    ecrc_a = '0;
    #3;
    chk("rst_rdy", 64'(bus_a.s_ready_o), 64'd0);
    chk("rst_clr", 64'(clr_a), 64'd0);
    chk("rst_evld", 64'(evld_a), 64'd0);
    chk("rst_cv", 64'(bus_a.crc_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_len", 64'(bus_a.len_o), 64'd0);
    chk("rst_crc", 64'(bus_a.crc_o), 64'd0);
    chk("rst_err", 64'(bus_a.err_o), 64'd0);
    chk("rst_b_cv", 64'(bus_b.crc_valid_o), 64'd0);
    chk("rst_b_busy", 64'(busy_b), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // single word frame
    bus_a.s_data_i = 48'hAB5766123dda;
    bus_a.s_last_i = 1'b1;
    bus_a.s_valid_i = 1'b1;
    ecrc_a = 32'hFFFF0000;
    chk("t1_clr_n", 64'(clr_a), 64'd0);
    tick();
    chk("t1_clr", 64'(clr_a), 64'd1);
    chk("t1_rdy_clr", 64'(bus_a.s_ready_o), 64'd0);
    tick();
    chk("t1_rdy", 64'(bus_a.s_ready_o), 64'd1);
    chk("t1_clr_off", 64'(clr_a), 64'd0);
    tick();
    bus_a.s_valid_i = 1'b0;
    bus_a.s_last_i = 1'b0;
    chk("t1_evld", 64'(evld_a), 64'd1);
    chk("t1_edata", 64'(edata_a), 64'hAB5766123dda);
    chk("t1_busy", 64'(busy_a), 64'd1);
    tick();
    chk("t1_cv_early", 64'(bus_a.crc_valid_o), 64'd0);
    chk("t1_evld_off", 64'(evld_a), 64'd0);
    ecrc_a = 32'h1234ABCD;
    tick();
    chk("t1_cv", 64'(bus_a.crc_valid_o), 64'd1);
    chk("t1_crc", 64'(bus_a.crc_o), 64'h1234ABCD);
    chk("t1_len", 64'(bus_a.len_o), 64'd1);
    chk("t1_err", 64'(bus_a.err_o), 64'd0);
    tick();
    chk("t1_cv_off", 64'(bus_a.crc_valid_o), 64'd0);
    chk("t1_idle", 64'(busy_a), 64'd0);

    // 4-word gapped frame, last on the MAX_WORDS-th word
    bus_a.s_data_i = w[0];
    bus_a.s_valid_i = 1'b1;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      bus_a.s_data_i = w[i];
      bus_a.s_last_i = (i == 3);
      bus_a.s_valid_i = 1'b1;
      chk("t2_rdy", 64'(bus_a.s_ready_o), 64'd1);
      tick();
      chk("t2_evld", 64'(evld_a), 64'd1);
      chk("t2_data", 64'(edata_a), 64'(w[i]));
      bus_a.s_valid_i = 1'b0;
      bus_a.s_last_i = 1'b0;
      if (i < 3) begin
        tick();
        chk("t2_gap", 64'(evld_a), 64'd0);
      end
    end
    ecrc_a = 32'hDEADBEEF;
    chk("t2_rdy_wait", 64'(bus_a.s_ready_o), 64'd0);
    tick();
    chk("t2_cv_early", 64'(bus_a.crc_valid_o), 64'd0);
    chk("t2_evld_off", 64'(evld_a), 64'd0);
    tick();
    chk("t2_cv", 64'(bus_a.crc_valid_o), 64'd1);
    chk("t2_crc", 64'(bus_a.crc_o), 64'hDEADBEEF);
    chk("t2_len", 64'(bus_a.len_o), 64'd4);
    chk("t2_err", 64'(bus_a.err_o), 64'd0);
    tick();
    chk("t2_idle", 64'(busy_a), 64'd0);
    chk("t2_no_drain", 64'(bus_a.s_ready_o), 64'd0);

    // 7-word frame overflows MAX_WORDS=4
    bus_a.s_data_i = w[0];
    bus_a.s_valid_i = 1'b1;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      bus_a.s_data_i = w[i];
      tick();
      chk("t3_evld", 64'(evld_a), 64'd1);
      chk("t3_data", 64'(edata_a), 64'(w[i]));
    end
    chk("t3_rdy_wait", 64'(bus_a.s_ready_o), 64'd0);
    bus_a.s_data_i = w[4];
    ecrc_a = 32'hCAFEF00D;
    tick();
    chk("t3_evld_off", 64'(evld_a), 64'd0);
    chk("t3_cv_early", 64'(bus_a.crc_valid_o), 64'd0);
    tick();
    chk("t3_cv", 64'(bus_a.crc_valid_o), 64'd1);
    chk("t3_err", 64'(bus_a.err_o), 64'd1);
    chk("t3_len", 64'(bus_a.len_o), 64'd4);
    chk("t3_crc", 64'(bus_a.crc_o), 64'hCAFEF00D);
    chk("t3_rdy_done", 64'(bus_a.s_ready_o), 64'd0);
    tick();
    for (int j = 4; j < 7; j++) begin
      bus_a.s_data_i = w[j];
      bus_a.s_last_i = (j == 6);
      chk("t3_drain_rdy", 64'(bus_a.s_ready_o), 64'd1);
      chk("t3_drain_cv", 64'(bus_a.crc_valid_o), 64'd0);
      tick();
      chk("t3_drain_evld", 64'(evld_a), 64'd0);
    end
    bus_a.s_valid_i = 1'b0;
    bus_a.s_last_i = 1'b0;
    chk("t3_idle", 64'(busy_a), 64'd0);

    // result backpressure for 10 cycles, next frame waiting
    bus_a.crc_ready_i = 1'b0;
    bus_a.s_data_i = 48'h000000C0FFEE;
    bus_a.s_last_i = 1'b1;
    bus_a.s_valid_i = 1'b1;
    tick(); tick(); tick();
    bus_a.s_data_i = 48'h00000000BEEF;
    ecrc_a = 32'h0BADF00D;
    tick(); tick();
    ecrc_a = 32'hFFFFFFFF;
    for (int k = 0; k < 10; k++) begin
      chk("t4_cv_hold", 64'(bus_a.crc_valid_o), 64'd1);
      chk("t4_crc_hold", 64'(bus_a.crc_o), 64'h0BADF00D);
      chk("t4_len_hold", 64'(bus_a.len_o), 64'd1);
      chk("t4_rdy_stall", 64'(bus_a.s_ready_o), 64'd0);
      tick();
    end
    chk("t4_cv_still", 64'(bus_a.crc_valid_o), 64'd1);
    bus_a.crc_ready_i = 1'b1;
    tick();
    chk("t4_cv_off", 64'(bus_a.crc_valid_o), 64'd0);
    chk("t4_clr_idle", 64'(clr_a), 64'd0);
    tick();
    chk("t4_clr2", 64'(clr_a), 64'd1);
    tick();
    chk("t4_rdy2", 64'(bus_a.s_ready_o), 64'd1);
    tick();
    bus_a.s_valid_i = 1'b0;
    bus_a.s_last_i = 1'b0;
    chk("t4_evld2", 64'(evld_a), 64'd1);
    chk("t4_data2", 64'(edata_a), 64'h00000000BEEF);
    ecrc_a = 32'h13579BDF;
    tick(); tick();
    chk("t4_cv2", 64'(bus_a.crc_valid_o), 64'd1);
    chk("t4_crc2", 64'(bus_a.crc_o), 64'h13579BDF);
    tick();

    // reset mid-frame after two words
    bus_a.s_data_i = w[5];
    bus_a.s_valid_i = 1'b1;
    tick(); tick(); tick();
    bus_a.s_data_i = w[6];
    tick();
    bus_a.s_valid_i = 1'b0;
    chk("t5_pre_evld", 64'(evld_a), 64'd1);
    chk("t5_pre_busy", 64'(busy_a), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_evld", 64'(evld_a), 64'd0);
    chk("t5_edata", 64'(edata_a), 64'd0);
    chk("t5_busy", 64'(busy_a), 64'd0);
    chk("t5_cv", 64'(bus_a.crc_valid_o), 64'd0);
    chk("t5_len", 64'(bus_a.len_o), 64'd0);
    chk("t5_crc", 64'(bus_a.crc_o), 64'd0);
    chk("t5_rdy", 64'(bus_a.s_ready_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_cv_rst", 64'(bus_a.crc_valid_o), 64'd0);
    bus_a.s_data_i = 48'h0000DEADD00D;
    bus_a.s_last_i = 1'b1;
    bus_a.s_valid_i = 1'b1;
    chk("t5_clr_idle", 64'(clr_a), 64'd0);
    tick();
    chk("t5_clr", 64'(clr_a), 64'd1);
    tick(); tick();
    bus_a.s_valid_i = 1'b0;
    bus_a.s_last_i = 1'b0;
    chk("t5_evld2", 64'(evld_a), 64'd1);
    ecrc_a = 32'h5A5A5A5A;
    tick(); tick();
    chk("t5_cv2", 64'(bus_a.crc_valid_o), 64'd1);
    chk("t5_len2", 64'(bus_a.len_o), 64'd1);
    chk("t5_crc2", 64'(bus_a.crc_o), 64'h5A5A5A5A);
    tick();

    // ENG_LAT=3, engine value changes every cycle
    bus_b.s_data_i = 48'h00000000AAAA;
    bus_b.s_valid_i = 1'b1;
    tick(); tick(); tick();
    chk("t6_evld0", 64'(evld_b), 64'd1);
    chk("t6_data0", 64'(edata_b), 64'h00000000AAAA);
    bus_b.s_data_i = 48'h00000000BBBB;
    bus_b.s_last_i = 1'b1;
    tick();
    c_last = cyc;
    bus_b.s_valid_i = 1'b0;
    bus_b.s_last_i = 1'b0;
    chk("t6_evld1", 64'(evld_b), 64'd1);
    chk("t6_data1", 64'(edata_b), 64'h00000000BBBB);
    exp_b = {16'hC0DE, c_last + 16'd3};
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_cv_early", 64'(bus_b.crc_valid_o), 64'd0);
    end
    tick();
    chk("t6_cv", 64'(bus_b.crc_valid_o), 64'd1);
    chk("t6_crc", 64'(bus_b.crc_o), 64'(exp_b));
    chk("t6_len", 64'(bus_b.len_o), 64'd2);
    chk("t6_err", 64'(bus_b.err_o), 64'd0);
    tick();
    chk("t6_idle", 64'(busy_b), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
